// File: rtl/generator_pkg.sv
// Shared types and constants for the shift-register burst sequencer:
// FSM state encoding, default burst lengths and burst counter width.
package generator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DYN  = 2'd1,
    STAT = 2'd2,
    GAP  = 2'd3
  } seq_state_t;

  localparam int DEF_SIZESRDYN  = 16;
  localparam int DEF_SIZESRSTAT = 88;
  localparam int CNT_W          = 7;

  // Terminal count of a phase lasting len cycles (counter runs 0..len-1).
  function automatic logic [CNT_W-1:0] last_count(input int len);
    return CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant logic for the burst sequencer. With SHIFT_SEQ_FIXED_PRIO_EN
// defined STAT always wins ties; otherwise ties alternate, STAT first after reset.
module rr_arbiter2 (
  input  logic CLK,
  input  logic RST_N,
  input  logic req_dyn,
  input  logic req_stat,
  input  logic update,
  output logic gnt_dyn,
  output logic gnt_stat
);

`ifdef SHIFT_SEQ_FIXED_PRIO_EN
  assign gnt_stat = req_stat;
  assign gnt_dyn  = req_dyn & ~req_stat;
`else
  // Set when DYN received the most recent grant, so STAT wins the next tie.
  logic last_dyn_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_dyn_reg <= 1'b1;
    end else if (update) begin
      last_dyn_reg <= gnt_dyn;
    end
  end

  assign gnt_stat = req_stat & (~req_dyn | last_dyn_reg);
  assign gnt_dyn  = req_dyn & (~req_stat | ~last_dyn_reg);
`endif

endmodule

// File: rtl/shift_sequencer.sv
// Burst sequencer driving shift-enables for a dynamic and a static shift register,
// with forced idle gaps and abort. Tie-break mode selected by SHIFT_SEQ_FIXED_PRIO_EN.
module shift_sequencer
  import generator_pkg::*;
#(
  parameter int SIZESRDYN  = DEF_SIZESRDYN,
  parameter int SIZESRSTAT = DEF_SIZESRSTAT,
  parameter int GAP_CYCLES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic REQ_DYN,
  input  logic REQ_STAT,
  input  logic ABORT,
  output logic SELDYN,
  output logic SELSTAT,
  output logic ACK_DYN,
  output logic ACK_STAT,
  output logic BIT_VALID,
  output logic BUSY
);

  localparam logic [CNT_W-1:0] DYN_LAST  = last_count(SIZESRDYN);
  localparam logic [CNT_W-1:0] STAT_LAST = last_count(SIZESRSTAT);
  localparam logic [CNT_W-1:0] GAP_LAST  = last_count(GAP_CYCLES);

  seq_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             seldyn_reg, selstat_reg, bit_valid_reg;
  logic             gnt_dyn, gnt_stat, grant_take;
  logic             ack_dyn_next, ack_stat_next;

  rr_arbiter2 u_arb (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .req_dyn  (REQ_DYN),
    .req_stat (REQ_STAT),
    .update   (grant_take),
    .gnt_dyn  (gnt_dyn),
    .gnt_stat (gnt_stat)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    grant_take    = 1'b0;
    ack_dyn_next  = 1'b0;
    ack_stat_next = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (gnt_stat) begin
          state_next = STAT;
          grant_take = 1'b1;
        end else if (gnt_dyn) begin
          state_next = DYN;
          grant_take = 1'b1;
        end
      end
      DYN: begin
        if (ABORT || cnt_reg == DYN_LAST) begin
          ack_dyn_next = 1'b1;
          state_next   = GAP;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STAT: begin
        if (ABORT || cnt_reg == STAT_LAST) begin
          ack_stat_next = 1'b1;
          state_next    = GAP;
          cnt_next      = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Shift-enables are flopped from the next state so they line up with the burst
  // state and clear together with it on reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      seldyn_reg    <= 1'b0;
      selstat_reg   <= 1'b0;
      bit_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      seldyn_reg    <= (state_next == DYN);
      selstat_reg   <= (state_next == STAT);
      bit_valid_reg <= seldyn_reg | selstat_reg;
    end
  end

  assign SELDYN    = seldyn_reg;
  assign SELSTAT   = selstat_reg;
  assign ACK_DYN   = ack_dyn_next;
  assign ACK_STAT  = ack_stat_next;
  assign BIT_VALID = bit_valid_reg;
  assign BUSY      = (state_reg != IDLE);

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter SIZESRDYN, 16, dynamic shift-register length in bits (burst length of a dynamic frame).
REQ-002 SHALL have parameter SIZESRSTAT, 88, static shift-register length in bits (burst length of a static frame).
REQ-003 SHALL have parameter GAP_CYCLES, 2, idle cycles forced between consecutive bursts (legal range 1..15).
REQ-004 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port REQ_DYN  input  1  level request for one dynamic frame.
REQ-007 SHALL have port REQ_STAT  input  1  level request for one static frame.
REQ-008 SHALL have port ABORT  input  1  synchronous pulse, terminates the current burst.
REQ-009 SHALL have port SELDYN  output  1  registered shift-enable to the dynamic register.
REQ-010 SHALL have port SELSTAT  output  1  registered shift-enable to the static register.
REQ-011 SHALL have port ACK_DYN  output  1  one-cycle pulse, dynamic frame completed or aborted.
REQ-012 SHALL have port ACK_STAT  output  1  one-cycle pulse, static frame completed or aborted.
REQ-013 SHALL have port BIT_VALID  output  1  high while the serial output bit downstream is frame data (SEL delayed one cycle).
REQ-014 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, DYN, STAT, GAP.
REQ-016 IDLE: sample requests each cycle; grant per REQ-022; REQ_DYN only -> DYN; REQ_STAT only -> STAT; none -> stay.
REQ-017 DYN SHALL assert SELDYN for exactly SIZESRDYN consecutive cycles, starting the cycle after the grant edge; STAT likewise SELSTAT for SIZESRSTAT cycles.
REQ-018 Burst counter SHALL be 7 bits, load 0 on entry, exit when count equals length-1; no wrap beyond length.
REQ-019 On the last burst cycle SHALL pulse the matching ACK for one cycle and go to GAP.
REQ-020 GAP SHALL hold SELDYN=SELSTAT=0 for exactly GAP_CYCLES cycles, then return to IDLE.
REQ-021 SELDYN and SELSTAT SHALL never be high in the same cycle.
REQ-022 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; after reset, STAT has priority.
REQ-023 Request deasserted mid-burst SHALL NOT shorten the burst; requester holds REQ until ACK and drops it the cycle after ACK, else a new frame is granted after GAP.
REQ-024 ABORT in DYN/STAT SHALL deassert SEL next cycle, pulse the matching ACK, go to GAP; ABORT in IDLE/GAP SHALL be ignored.
REQ-025 BIT_VALID SHALL equal (SELDYN|SELSTAT) delayed one cycle, matching the registered serial output of the generator.

Reset
REQ-026 While RST_N low: state IDLE, counters 0, SELDYN=SELSTAT=ACK_DYN=ACK_STAT=BIT_VALID=BUSY=0, round-robin pointer favours STAT.
REQ-027 Reset asserted mid-burst SHALL drop SEL immediately (asynchronously) with no ACK issued.

Configuration
REQ-028 Macro SHIFT_SEQ_FIXED_PRIO_EN defined: simultaneous requests always grant STAT, round-robin pointer removed; undefined: round-robin per REQ-022.

Structure
REQ-029 Shared package generator_pkg SHALL hold the FSM state enum, default sizes 16/88, and counter width constant 7.
REQ-030 Sub-module rr_arbiter2 SHALL contain the two-requester round-robin grant logic and pointer register.

Verification
REQ-031 REQ_DYN held from reset release -> SELDYN high 16 cycles, ACK_DYN on 16th, 2 gap cycles, BIT_VALID high 16 cycles lagging by 1.
REQ-032 REQ_STAT and REQ_DYN both high continuously -> STAT 88, gap 2, DYN 16, gap 2, STAT 88 (undefined macro); with macro STAT repeats only.
REQ-033 ABORT at 10th SELSTAT cycle -> SELSTAT low next cycle, ACK_STAT pulse, GAP 2 cycles, then IDLE.
REQ-034 RST_N low at 5th SELDYN cycle -> SELDYN low immediately, no ACK, IDLE after release.
REQ-035 REQ_DYN one-cycle pulse -> full 16-cycle burst still issued; ABORT in IDLE -> no effect.
REQ-036 Every run: assertion SELDYN&SELSTAT never 1; BUSY low only in IDLE.
